// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared-ALU arbiter.
// Operand buses are packed per requester: slice i = [i*WIDTH +: WIDTH], c/op = [i*2 +: 2].
interface alu_rr_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*2-1:0]     req_c;
    logic [NREQ*2-1:0]     req_op;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [WIDTH-1:0]      resp_data;

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_c, req_op, resp_ready,
        output req_ready, resp_valid, resp_data
    );

    // Requester side
    modport master (
        output req_valid, req_a, req_b, req_c, req_op, resp_ready,
        input  req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Each transaction walks IDLE (grant + latch operands) -> EXEC (capture ALU answer)
// -> RESP (return result to the granted requester until it is taken).
module alu_rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_rr_arbiter_if.slave  io,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_c,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_ans,
    output logic             busy
);
    localparam int unsigned NR = NREQ;
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    last_gnt_q, last_gnt_d;
    logic [GW-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       c_q, c_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;

    logic [GW-1:0]    pick;
    logic [GW-1:0]    cand;
    logic             any_valid;
    logic [NREQ-1:0]  req_ready;
    logic [NREQ-1:0]  resp_valid;

    // Round-robin search: first valid index after last_gnt, wrapping modulo NREQ
    always_comb begin
        pick      = '0;
        cand      = '0;
        any_valid = 1'b0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand = GW'((32'(last_gnt_q) + k) % NR);
            if (!any_valid && io.req_valid[cand]) begin
                any_valid = 1'b1;
                pick      = cand;
            end
        end
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        gnt_d       = gnt_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        op_d        = op_q;
        resp_data_d = resp_data_q;
        req_ready   = '0;
        resp_valid  = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready[pick] = 1'b1;
                    gnt_d   = pick;
                    a_d     = io.req_a[pick*WIDTH +: WIDTH];
                    b_d     = io.req_b[pick*WIDTH +: WIDTH];
                    c_d     = io.req_c[pick*2 +: 2];
                    op_d    = io.req_op[pick*2 +: 2];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_data_d = alu_ans;
                state_d     = RESP;
            end
            RESP: begin
                resp_valid[gnt_q] = 1'b1;
                // last_gnt only advances on completion, so a request arriving
                // with resp_ready is arbitrated in the following IDLE cycle
                if (io.resp_ready[gnt_q]) begin
                    last_gnt_d = gnt_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_gnt_q  <= LAST_INIT;
            gnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            op_q        <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            op_q        <= op_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign io.req_ready  = req_ready;
    assign io.resp_valid = resp_valid;
    assign io.resp_data  = resp_data_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_c         = c_q;
    assign alu_op        = op_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: the driver predicts winner and result
// from an arithmetic model and queues them; a monitor pops on each response handshake.
module tb_alu_rr_arbiter;
    localparam int NREQ  = 2;
    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    typedef struct {
        int id;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [WIDTH-1:0] alu_a, alu_b, alu_ans;
    logic [1:0]       alu_c, alu_op;
    logic             busy;

    alu_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    alu_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io     (bus),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_c  (alu_c),
        .alu_op (alu_op),
        .alu_ans(alu_ans),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // The external combinational ALU
    always_comb begin
        alu_ans = '0;
        case (alu_op)
            2'b00: alu_ans = $signed(alu_a) >>> alu_c;
            2'b01: alu_ans = alu_a >> alu_c;
            2'b10: alu_ans = alu_a - alu_b;
            2'b11: alu_ans = alu_a + alu_b;
            default: alu_ans = '0;
        endcase
    end

    int   n_vec = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   model_last = NREQ - 1;
    int   op_a[NREQ], op_b[NREQ], op_c[NREQ], op_op[NREQ];
    bit   rr_force = 1'b1;
    logic [NREQ-1:0] rr_val = '1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference ALU from plain integer arithmetic
    function automatic int ref_result(input int a, input int b, input int c, input int op);
        int sa, r;
        case (op)
            0: begin
                sa = (a >= MOD / 2) ? a - MOD : a;
                r  = sa >>> c;
            end
            1: r = a / (1 << c);
            2: r = a - b;
            default: r = a + b;
        endcase
        return ((r % MOD) + MOD) % MOD;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic int predict(input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input int a, input int b, input int c, input int op);
        op_a[i] = a; op_b[i] = b; op_c[i] = c; op_op[i] = op;
        bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
        bus.req_c[i*2 +: 2]         = 2'(c);
        bus.req_op[i*2 +: 2]        = 2'(op);
    endtask

    // Issue one request pattern; returns at the sample point where the response should be visible
    task automatic issue(input logic [NREQ-1:0] m);
        int  w;
        bit  got;
        exp_t e;
        w = predict(m);
        e.id = w;
        e.data = ref_result(op_a[w], op_b[w], op_c[w], op_op[w]);
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.req_valid = m;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready != '0) got = 1'b1;
        end
        if (!got) begin
            fail_now("grant_wait");
            bus.req_valid = '0;
            void'(exp_q.pop_back());
            return;
        end
        chk("grant", 32'(bus.req_ready), 32'(onehot(w)));
        model_last = w;
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("exec_no_resp", 32'(bus.resp_valid), 32'd0);
        chk("alu_operands", 32'({alu_a, alu_b, alu_c, alu_op}),
            32'((op_a[w] << (WIDTH + 4)) | (op_b[w] << 4) | (op_c[w] << 2) | op_op[w]));
        @(negedge clk);
        chk("resp_latency", 32'(bus.resp_valid), 32'(onehot(w)));
    endtask

    // resp_ready source: random unless forced by the directed tests
    initial begin
        bus.resp_ready = '0;
        forever begin
            @(posedge clk); #1;
            bus.resp_ready = rr_force ? rr_val : NREQ'($urandom);
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on each response handshake
    initial begin : monitor
        bit              prev_hold;
        logic [NREQ-1:0] prev_v;
        logic [WIDTH-1:0] prev_d;
        exp_t            e;
        prev_hold = 1'b0;
        prev_v = '0;
        prev_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (busy) chk("no_ready_when_busy", 32'(bus.req_ready), 32'd0);
                if (prev_hold) begin
                    chk("hold_valid", 32'(bus.resp_valid), 32'(prev_v));
                    chk("hold_data", 32'(bus.resp_data), 32'(prev_d));
                end
                if ((bus.resp_valid & bus.resp_ready) != '0) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_resp: got valid %0h, expected none", bus.resp_valid);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_id", 32'(bus.resp_valid), 32'(onehot(e.id)));
                        chk("resp_data", 32'(bus.resp_data), 32'(e.data));
                    end
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = (bus.resp_valid != '0);
                    prev_v    = bus.resp_valid;
                    prev_d    = bus.resp_data;
                end
            end
        end
    end

    initial begin : driver
        int unsigned t_prev;
        bit got;
        exp_t e;
        t_prev = 0;
        bus.req_valid = '0;
        bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_op = '0;
        for (int i = 0; i < NREQ; i++) set_op(i, 0, 0, 0, 0);

        // Reset values
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_regs", 32'({bus.resp_data, alu_a, alu_b, alu_c, alu_op}), 32'd0);
        #21 rst_n = 1'b1;

        // Add, arithmetic and logical shift, wrap-around
        set_op(0, 5, 3, 0, 3);
        issue(2'b01);
        chk("t1_add", 32'(bus.resp_data), 32'd8);
        set_op(1, 8, 0, 2, 0);
        issue(2'b10);
        chk("t2_ashr", 32'(bus.resp_data), 32'hE);
        set_op(1, 8, 0, 2, 1);
        issue(2'b10);
        chk("t2_lshr", 32'(bus.resp_data), 32'h2);
        set_op(0, 2, 3, 0, 2);
        issue(2'b01);
        chk("t3_sub_wrap", 32'(bus.resp_data), 32'hF);
        set_op(0, 15, 1, 0, 3);
        issue(2'b01);
        chk("t3_add_wrap", 32'(bus.resp_data), 32'h0);

        // Backpressure for several cycles
        rr_val = '0;
        set_op(0, 7, 9, 0, 2);
        issue(2'b01);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.resp_valid), 32'b01);
            chk("bp_data", 32'(bus.resp_data), 32'hE);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        rr_val = '1;
        @(negedge clk);
        chk("bp_release_cycle", 32'(bus.resp_valid), 32'b01);
        @(negedge clk);
        chk("bp_done_valid", 32'(bus.resp_valid), 32'd0);
        chk("bp_done_busy", 32'(busy), 32'd0);

        // Reset during RESP drops the transaction
        rr_val = '0;
        set_op(1, 3, 2, 0, 3);
        issue(2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_regs", 32'({bus.resp_data, alu_a, alu_b, alu_c, alu_op}), 32'd0);
        exp_q.delete();
        model_last = NREQ - 1;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rr_val = '1;

        // Fairness with both requesters valid continuously
        set_op(0, 1, 2, 1, 3);
        set_op(1, 9, 4, 3, 0);
        bus.req_valid = '1;
        for (int g = 0; g < 4; g++) begin
            e.id = g % NREQ;
            e.data = ref_result(op_a[e.id], op_b[e.id], op_c[e.id], op_op[e.id]);
            exp_q.push_back(e);
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (bus.req_ready != '0) got = 1'b1;
            end
            if (!got) fail_now("fair_grant_wait");
            else begin
                chk("fair_order", 32'(bus.req_ready), 32'(onehot(g % NREQ)));
                if (g > 0) chk("fair_period", cyc - t_prev, 32'd3);
                t_prev = cyc;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        model_last = (4 - 1) % NREQ;

        // Randomized traffic with random response backpressure
        rr_force = 1'b0;
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < NREQ; i++)
                set_op(i, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            issue(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
        end

        // Drain outstanding responses
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) fail_now("drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
